// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with seven-segment decode.
// Optional leading-zero blanking of the segment outputs when LZ_BLANK_EN is defined.
module bcd_seq_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Decimal digit count of the largest WIDTH-bit value.
    function automatic int min_digits(input int w);
        longint unsigned v;
        int              d;
        v = (64'd1 << w) - 64'd1;
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $error("bcd_seq_converter: WIDTH must be within 4..32");
        end
        if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
            $error("bcd_seq_converter: DIGITS too small for WIDTH");
        end
    endgenerate

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0011000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [WIDTH-1:0]      operand_q, operand_d;
    logic [4*DIGITS-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]      count_q,   count_d;
    logic [4*DIGITS-1:0]   bcd_q,     bcd_d;
    logic [7*DIGITS-1:0]   seg_q,     seg_d;
    logic [4*DIGITS-1:0]   adjusted;
    logic [7*DIGITS-1:0]   seg_next;

    always_comb begin
        adjusted = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Segment image of the finished scratch; only ever registered on entry to DONE.
    always_comb begin : p_seg_next
`ifdef LZ_BLANK_EN
        logic leading;
        leading = 1'b1;
`endif
        seg_next = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seg_next[7*k +: 7] = seg_decode(scratch_q[4*k +: 4]);
`ifdef LZ_BLANK_EN
            if (k != 0 && leading && scratch_q[4*k +: 4] == 4'd0) begin
                seg_next[7*k +: 7] = 7'b1111111;
            end else begin
                leading = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        seg_d     = seg_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    operand_d = binary;
                    scratch_d = '0;
                    count_d   = CNT_W'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // The cycle after the last shift publishes the result.
                if (count_q != '0) begin
                    {scratch_d, operand_d} = {adjusted, operand_q} << 1;
                    count_d = count_q - CNT_W'(1);
                end else begin
                    bcd_d   = scratch_q;
                    seg_d   = seg_next;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            operand_q <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
            seg_q     <= '1;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            seg_q     <= seg_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: an 8-bit and a 16-bit instance checked
// against a decimal-arithmetic model; honours LZ_BLANK_EN when defined.
module tb_bcd_seq_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [7:0]  bin0 = '0;
    logic [15:0] bin1 = '0;
    logic        busy0, done0, busy1, done1;
    logic [11:0] bcd0;
    logic [20:0] seg0;
    logic [19:0] bcd1;
    logic [34:0] seg1;

    always #5 clk = ~clk;

    bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start0), .binary(bin0),
        .busy(busy0), .done(done0), .bcd(bcd0), .seg(seg0)
    );

    bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start1), .binary(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .seg(seg1)
    );

    typedef struct {
        logic [19:0] bcd;
        logic [34:0] seg;
        int          done_edge;
    } exp_t;

    localparam logic [6:0] SEG_TAB [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };

    exp_t sb0[$];
    exp_t sb1[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    bit   act[2];
    int   lacc[2];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Decimal digits by repeated division; blanking from the count of significant digits.
    function automatic exp_t model(int unsigned v, int nd);
        exp_t        r;
        int unsigned t;
        int          sig;
        r.bcd = '0;
        r.seg = '0;
        r.done_edge = 0;
        t = v;
        sig = 1;
        for (int k = 0; k < nd; k++) begin
            if (t != 0) sig = k + 1;
            r.bcd[4*k +: 4] = 4'(t % 10);
            r.seg[7*k +: 7] = SEG_TAB[t % 10];
            t = t / 10;
        end
`ifdef LZ_BLANK_EN
        for (int k = 1; k < nd; k++) begin
            if (k >= sig) r.seg[7*k +: 7] = 7'b1111111;
        end
`endif
        return r;
    endfunction

    task automatic compareValue(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic checkOutput(int i, logic d, logic b, logic [19:0] bc, logic [34:0] sg);
        int   w;
        int   n;
        exp_t e;
        logic exp_busy;
        w = (i == 0) ? 8 : 16;
        exp_busy = act[i] && rst_n && edge_cnt >= lacc[i] && edge_cnt <= lacc[i] + w;
        compareValue($sformatf("inst%0d busy @edge %0d", i, edge_cnt), 64'(b), 64'(exp_busy));
        n = (i == 0) ? sb0.size() : sb1.size();
        if (n > 0) begin
            if (i == 0) e = sb0[0];
            else        e = sb1[0];
        end
        if (d === 1'b1) begin
            if (n == 0) begin
                compareValue($sformatf("inst%0d unexpected done @edge %0d", i, edge_cnt), 64'd1, 64'd0);
            end else begin
                if (i == 0) void'(sb0.pop_front());
                else        void'(sb1.pop_front());
                compareValue($sformatf("inst%0d done edge", i), 64'(edge_cnt), 64'(e.done_edge));
                compareValue($sformatf("inst%0d bcd", i), 64'(bc), 64'(e.bcd));
                compareValue($sformatf("inst%0d seg", i), 64'(sg), 64'(e.seg));
            end
        end else if (n > 0 && e.done_edge <= edge_cnt) begin
            if (i == 0) void'(sb0.pop_front());
            else        void'(sb1.pop_front());
            compareValue($sformatf("inst%0d missing done (edge)", i), 64'(edge_cnt), 64'(e.done_edge));
        end
    endtask

    always @(negedge clk) begin
        checkOutput(0, done0, busy0, 20'(bcd0), 35'(seg0));
        checkOutput(1, done1, busy1, bcd1, seg1);
    end

    // Drives one cycle of stimulus; the model decides acceptance from edge numbers alone.
    task automatic applyStimulus(int i, bit s, int unsigned b);
        int   e;
        int   w;
        exp_t x;
        @(negedge clk);
        #1;
        start0 = (i == 0) && s;
        start1 = (i == 1) && s;
        if (i == 0) bin0 = b[7:0];
        else        bin1 = b[15:0];
        w = (i == 0) ? 8 : 16;
        e = edge_cnt + 1;
        if (s && rst_n && (!act[i] || e >= lacc[i] + w + 2)) begin
            act[i]  = 1'b1;
            lacc[i] = e;
            x = model((i == 0) ? (b & 32'hFF) : (b & 32'hFFFF), (i == 0) ? 3 : 5);
            x.done_edge = e + w + 1;
            if (i == 0) sb0.push_back(x);
            else        sb1.push_back(x);
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 1'b0, 0);
    endtask

    task automatic resetChecks();
        compareValue("reset busy0", 64'(busy0), 64'd0);
        compareValue("reset done0", 64'(done0), 64'd0);
        compareValue("reset bcd0",  64'(bcd0),  64'd0);
        compareValue("reset seg0",  64'(seg0),  64'h1FFFFF);
        compareValue("reset busy1", 64'(busy1), 64'd0);
        compareValue("reset done1", 64'(done1), 64'd0);
        compareValue("reset bcd1",  64'(bcd1),  64'd0);
        compareValue("reset seg1",  64'(seg1),  64'h7_FFFF_FFFF);
    endtask

    task automatic doReset(int hold);
        @(negedge clk);
        #1;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        act[0] = 1'b0;
        act[1] = 1'b0;
        sb0.delete();
        sb1.delete();
        #1;
        resetChecks();
        repeat (hold) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned r;
        act[0] = 1'b0;
        act[1] = 1'b0;
        lacc[0] = 0;
        lacc[1] = 0;
        #2;
        doReset(2);

        applyStimulus(0, 1'b1, 255);
        idle(12);
        applyStimulus(0, 1'b1, 0);
        idle(12);

        // Second start arrives mid-conversion and must be ignored.
        applyStimulus(0, 1'b1, 7);
        idle(2);
        applyStimulus(0, 1'b1, 200);
        idle(12);

        // Reset four shifts into a conversion: nothing may complete.
        applyStimulus(0, 1'b1, 128);
        idle(4);
        doReset(2);
        applyStimulus(0, 1'b1, 99);
        idle(12);

        // start held high: first accept with 1, next accept in DONE with 42.
        applyStimulus(0, 1'b1, 1);
        for (int k = 0; k < 10; k++) applyStimulus(0, 1'b1, 42);
        idle(12);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 5);
            if (r == 0)      applyStimulus(0, 1'b1, 255);
            else if (r == 1) applyStimulus(0, 1'b1, 0);
            else if (r <= 3) applyStimulus(0, 1'b1, $urandom_range(0, 255));
            else             applyStimulus(0, 1'b0, $urandom_range(0, 255));
        end
        idle(12);

        applyStimulus(1, 1'b1, 65535);
        idle(20);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1, 1'b1, $urandom_range(0, 65535));
            for (int k = 0; k < 18; k++) applyStimulus(1, 1'b1, $urandom_range(0, 65535));
        end
        idle(25);

        compareValue("inst0 pending results", 64'(sb0.size()), 64'd0);
        compareValue("inst1 pending results", 64'(sb1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_seq_converter.md
BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

Interface
REQ-001 Parameter WIDTH, default 8, is the binary input width in bits; legal range 4..32.
REQ-002 Parameter DIGITS, default 3, is the number of BCD/seven-segment output digits; it SHALL be at least ceil(WIDTH*log10(2)), and an illegal value SHALL stop elaboration.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 start  input  1  is a conversion request, sampled on the rising edge of clk.
REQ-006 binary  input  WIDTH  is the unsigned value to convert, captured on an accepted start.
REQ-007 busy  output  1  is high while a conversion is in progress.
REQ-008 done  output  1  is a one-cycle pulse marking that a new result is valid.
REQ-009 bcd  output  4*DIGITS  holds the result digits; digit k occupies bits [4k+3:4k]; k=0 is the ones digit.
REQ-010 seg  output  7*DIGITS  holds the seven-segment patterns; digit k occupies bits [7k+6:7k].
REQ-011 Segment patterns SHALL be active-low with bit order {g,f,e,d,c,b,a}.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch binary, clear the BCD scratch register, load the bit counter with WIDTH, and go to SHIFT.
REQ-014 In SHIFT, each cycle SHALL do the following, MSB first:
  - add 3 to every scratch digit that is >= 5;
  - shift the {scratch, operand} register left by one bit;
  - decrement the counter.
REQ-015 The FSM SHALL leave SHIFT after exactly WIDTH shifts.
REQ-016 On the edge that leaves SHIFT, the block SHALL:
  - load the scratch into bcd;
  - load the decoded patterns into seg;
  - go to DONE.
REQ-017 DONE SHALL last one cycle, with done=1 and busy=0, and then return to IDLE.
REQ-018 Latency: if start is accepted at edge N, done SHALL be high in the cycle following edge N+WIDTH+1.
REQ-019 busy SHALL be high from edge N through edge N+WIDTH and low in DONE and IDLE.
REQ-020 start while busy=1 SHALL be ignored; the latched operand SHALL NOT change.
REQ-021 start during the DONE cycle SHALL be accepted, giving back-to-back conversions at a WIDTH+2 cycle period.
REQ-022 bcd and seg SHALL hold their last result until the next DONE entry; they SHALL never show intermediate scratch values.
REQ-023 Digit decode:
  - 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000, 4 -> 0011001;
  - 5 -> 0010010, 6 -> 0000010, 7 -> 1111000, 8 -> 0000000, 9 -> 0011000;
  - codes 10..15 -> 1111111 (blank).
REQ-024 All arithmetic SHALL be unsigned; the maximum input 2^WIDTH-1 SHALL convert without overflow of the top digit.

Reset
REQ-025 Asserting rst_n=0 SHALL act immediately, independent of clk, and SHALL:
  - set the FSM to IDLE;
  - set busy=0, done=0 and bcd=0;
  - set every seg digit to 1111111;
  - clear the scratch register, operand register and counter.
REQ-026 Reset during SHIFT SHALL abort the conversion; no done SHALL follow, and the first start after release SHALL convert normally.
REQ-027 Release of rst_n SHALL take effect on the first rising clk edge after deassertion.

Configuration
REQ-028 Macro LZ_BLANK_EN SHALL control leading-zero blanking.
REQ-029 With LZ_BLANK_EN defined:
  - every digit above the most significant nonzero digit SHALL show seg=1111111;
  - the ones digit SHALL always be displayed, so a value of 0 shows a single "0";
  - bcd SHALL be unaffected.
REQ-030 Without LZ_BLANK_EN, every digit SHALL show its decoded pattern, including leading zeros.

Verification
REQ-031 WIDTH=8, binary=255, start pulse -> done exactly 9 cycles after the start edge; bcd=12'h255; seg hundreds/tens/ones = 0100100 / 0010010 / 0010010.
REQ-032 WIDTH=8, binary=0 -> bcd=0:
  - without LZ_BLANK_EN: all three digits show 1000000;
  - with LZ_BLANK_EN: hundreds and tens show 1111111, ones shows 1000000.
REQ-033 Start with binary=7; 3 cycles later start with binary=200 -> single done; bcd=12'h007; the second start is ignored.
REQ-034 Start with binary=128, then rst_n=0 for 2 cycles at shift 4, then release -> no done; outputs are reset values; a new start with 99 -> bcd=12'h099.
REQ-035 Back-to-back: start held high with binary=1 then 42 -> done pulses 10 cycles apart; bcd sequence 12'h001 then 12'h042.
REQ-036 WIDTH=16, DIGITS=5, binary=65535 -> bcd=20'h65535; done 17 cycles after the start edge.
